// File: rtl/bcd_scan_display.sv
// Multiplexed 4-digit MM.SS seven-segment driver with per-frame BCD snapshot,
// leading-zero blanking and whole-display blinking.
module bcd_scan_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk_in,
    input  logic        RESET,
    input  logic [16:1] bcd_in,
    input  logic        blank_lead,
    input  logic        blink,
    output logic [4:1]  an,
    output logic [7:1]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        D1 = 2'd0,
        D2 = 2'd1,
        D3 = 2'd2,
        D4 = 2'd3
    } digit_t;

    digit_t        idx_q;
    digit_t        idx_d;
    logic [PW-1:0] presc_q;
    logic [16:1]   snap_q;
    logic [FW-1:0] frame_q;
    logic          phase_q;

    logic          slot_tick;
    logic          capture;

    assign slot_tick = (presc_q == PRESC_LAST);
    assign capture   = slot_tick && (idx_q == D4);

    // Slot prescaler
    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            presc_q <= '0;
        end else if (slot_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Digit index state register
    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            idx_q <= D1;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (slot_tick) begin
            unique case (idx_q)
                D1: idx_d = D2;
                D2: idx_d = D3;
                D3: idx_d = D4;
                D4: idx_d = D1;
            endcase
        end
    end

    // Snapshot is taken only at the end of a full scan so every frame is coherent
    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            snap_q     <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= capture;
            if (capture) begin
                snap_q <= bcd_in;
            end
        end
    end

    // Blink frame counter; held clear while blink is off so blinking starts visible
    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else if (!blink) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else if (capture) begin
            if (frame_q == FRAME_LAST) begin
                frame_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                frame_q <= frame_q + FW'(1);
            end
        end
    end

    function automatic logic [7:1] decode(input logic [3:0] v);
        logic [7:1] s;
        unique case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [3:0] nib;
    logic [4:1] an_sel;
    logic [4:1] an_d;
    logic [7:1] seg_d;
    logic       dp_d;
    logic       dark;
    logic       blank4;

    always_comb begin
        nib    = 4'd0;
        an_sel = 4'b1111;
        unique case (idx_q)
            D1: begin
                nib    = snap_q[4:1];
                an_sel = 4'b1110;
            end
            D2: begin
                nib    = snap_q[8:5];
                an_sel = 4'b1101;
            end
            D3: begin
                nib    = snap_q[12:9];
                an_sel = 4'b1011;
            end
            D4: begin
                nib    = snap_q[16:13];
                an_sel = 4'b0111;
            end
        endcase
    end

    always_comb begin
        dark   = blink && phase_q;
        blank4 = blank_lead && (snap_q[16:13] == 4'd0) && (idx_q == D4);
        seg_d  = decode(nib);
        dp_d   = (idx_q != D3);
        an_d   = an_sel;
        if (dark || blank4) begin
            an_d = 4'b1111;
        end
    end

    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
